// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: steers a W-then-X element stream into the datapath memory bank by (row, col).
module matrix_load_sequencer #(
   parameter int DW = 4,
   parameter int AW = 2,
   parameter int N  = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] data_in,
   output logic          clear_mem,
   output logic [AW-1:0] row_w,
   output logic [AW-1:0] col_w,
   output logic [AW-1:0] row_x,
   output logic [AW-1:0] col_x,
   output logic          busy,
   output logic          frame_done
);
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, LOAD_X, DONE} state_t;
   localparam logic [AW-1:0] NO_ADDR = '1;
   localparam logic [AW-1:0] LAST = AW'(N - 1);
   state_t state, state_nx;
   logic [AW-1:0] row, col;
   logic xfer, last;
   assign in_ready = state == LOAD_W || state == LOAD_X;
   assign xfer = in_ready && in_valid;
   assign last = row == LAST && col == LAST;
   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = CLEAR;
      else if (state == CLEAR) state_nx = LOAD_W;
      else if (state == LOAD_W && xfer && last) state_nx = LOAD_X;
      else if (state == LOAD_X && xfer && last) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // Address outputs default to the idle code every cycle, so a stalled source never repeats a write.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         data_in    <= '0;
         clear_mem  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         row_w      <= NO_ADDR;
         col_w      <= NO_ADDR;
         row_x      <= NO_ADDR;
         col_x      <= NO_ADDR;
      end else begin
         clear_mem  <= state == IDLE && start;
         busy       <= state != IDLE || start;
         frame_done <= state == DONE;
         row_w      <= (xfer && state == LOAD_W) ? row : NO_ADDR;
         col_w      <= (xfer && state == LOAD_W) ? col : NO_ADDR;
         row_x      <= (xfer && state == LOAD_X) ? row : NO_ADDR;
         col_x      <= (xfer && state == LOAD_X) ? col : NO_ADDR;
         if (xfer) data_in <= in_data;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (state == CLEAR || (xfer && last)) begin
         row <= '0;
         col <= '0;
      end else if (xfer) begin
         col <= col == LAST ? '0 : col + 1'b1;
         row <= col == LAST ? row + 1'b1 : row;
      end
endmodule
